// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester arbiter for a single BRAM port with burst-limited fairness
// and in-order read data return tagged per requester.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 16
) (
    input  logic                  w_clk,
    input  logic                  w_resetn,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  busy
);

    logic                    last_grant;
    logic [7:0]              cnt;
    logic [READ_LATENCY-1:0] sr_rd;
    logic [READ_LATENCY-1:0] sr_id;
    logic                    both;
    logic                    keep;
    logic                    gnt1;

    // A fresh contention (cnt==0) goes to the non-owner, so the reset value of 1 favours req0.
    always_comb begin
        both       = req0_valid & req1_valid;
        keep       = (cnt != 8'd0) && (cnt < 8'(MAX_BURST));
        gnt1       = both ? (keep ? last_grant : ~last_grant) : req1_valid;
        req1_ready = w_resetn & req1_valid & gnt1;
        req0_ready = w_resetn & req0_valid & ~gnt1;
        bram_en    = req0_ready | req1_ready;
        bram_we    = req1_ready ? req1_we : (req0_ready & req0_we);
        bram_addr  = req1_ready ? req1_addr : req0_addr;
        bram_din   = req1_ready ? req1_wdata : req0_wdata;
        busy       = (|sr_rd) | req0_rvalid | req1_rvalid;
    end

    always_ff @(posedge w_clk) begin
        if (!w_resetn) begin
            last_grant  <= 1'b1;
            cnt         <= 8'd0;
            sr_rd       <= '0;
            sr_id       <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            rdata       <= '0;
        end else begin
            if (bram_en)
                last_grant <= req1_ready;
            cnt         <= !both ? 8'd0 : (req1_ready != last_grant) ? 8'd1 :
                           (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            sr_rd       <= READ_LATENCY'({sr_rd, bram_en & ~bram_we});
            sr_id       <= READ_LATENCY'({sr_id, req1_ready});
            req0_rvalid <= sr_rd[READ_LATENCY-1] & ~sr_id[READ_LATENCY-1];
            req1_rvalid <= sr_rd[READ_LATENCY-1] & sr_id[READ_LATENCY-1];
            rdata       <= bram_dout;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed vectors against a 2-cycle BRAM model, with a
// scoreboard checking grants, BRAM drive, busy and in-order read return.
module tb_bram_port_arbiter;

    logic        w_clk = 1'b0;
    logic        w_resetn = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [10:0] req0_addr = '0;
    logic [7:0]  req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [10:0] req1_addr = '0;
    logic [7:0]  req1_wdata = '0;
    logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [7:0]  rdata;
    logic        bram_en, bram_we;
    logic [10:0] bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout = '0;
    logic        busy;

    bram_port_arbiter dut (
        .w_clk(w_clk), .w_resetn(w_resetn),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .rdata(rdata), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
    );

    always #5 w_clk = ~w_clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int n_rv0 = 0;
    int n_rv1 = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [7:0] mem [2048];
    logic [7:0] exp_mem [2048];
    logic [7:0] d1 = '0;

    initial
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 8'((i * 37 + 11) & 255);
            exp_mem[i] = 8'((i * 37 + 11) & 255);
        end

    always @(posedge w_clk) begin
        cyc <= cyc + 1;
        if (bram_en) begin
            if (bram_we)
                mem[bram_addr] <= bram_din;
            d1 <= mem[bram_addr];
        end
        bram_dout <= d1;
    end

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } rd_t;
    rd_t q[$];

    always @(negedge w_clk) begin
        rd_t         e;
        logic        id, we;
        logic [10:0] a;
        logic [7:0]  d;
        if (mon_en) begin
            chk("rdy_excl", req0_ready & req1_ready, 0);
            chk("rdy_no_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);
            chk("rv_excl", req0_rvalid & req1_rvalid, 0);
            chk("busy", busy, q.size() != 0);
            if (req0_rvalid | req1_rvalid) begin
                if (req0_rvalid) n_rv0++;
                if (req1_rvalid) n_rv1++;
                if (q.size() == 0)
                    chk("rv_spurious", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rv_id", req1_rvalid, e.id);
                    chk("rdata", rdata, e.data);
                    chk("rv_latency", cyc - e.cyc, 3);
                end
            end
            if (!w_resetn) begin
                chk("rst_ready", req0_ready | req1_ready, 0);
                chk("rst_en", bram_en | bram_we, 0);
                q.delete();
            end else if (req0_valid | req1_valid) begin
                id = req1_ready;
                we = id ? req1_we : req0_we;
                a  = id ? req1_addr : req0_addr;
                d  = id ? req1_wdata : req0_wdata;
                chk("grant_any", req0_ready | req1_ready, 1);
                chk("bram_en", bram_en, 1);
                chk("bram_we", bram_we, we);
                chk("bram_addr", bram_addr, a);
                chk("bram_din", bram_din, d);
                if (we)
                    exp_mem[a] = d;
                else
                    q.push_back('{id, exp_mem[a], cyc});
            end else
                chk("idle_en", bram_en | bram_we, 0);
        end
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        int g, base;
        w_resetn   = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) step();
        mon_en = 1'b1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_bram_en", bram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", req0_rvalid | req1_rvalid, 0);
        chk("rst_rdata", rdata, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        w_resetn   = 1'b1;
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 11'h010;
        req0_wdata = 8'hA5;
        #1 chk("wr_ready0", req0_ready, 1);
        base = n_rv0;
        step();
        req0_we = 1'b0;
        step();
        req0_valid = 1'b0;
        repeat (5) step();
        chk("wr_rd_rvalids", n_rv0 - base, 1);
        chk("wr_rd_mem", exp_mem[11'h010], 8'hA5);

        w_resetn   = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = 11'h020;
        req1_addr  = 11'h030;
        repeat (2) step();
        w_resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            g = req0_ready ? 0 : req1_ready ? 1 : 2;
            chk($sformatf("burst_grant_%0d", i), g, (i < 16 || i >= 32) ? 0 : 1);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) step();

        base       = n_rv1;
        req1_valid = 1'b1;
        req1_addr  = 11'd0;
        for (int k = 0; k < 40; k++) begin
            #1 chk("stream_ready1", req1_ready, 1);
            step();
            req1_addr = 11'(k + 1);
        end
        req1_valid = 1'b0;
        repeat (6) step();
        chk("stream_rvalids", n_rv1 - base, 40);

        base       = n_rv0;
        req0_valid = 1'b1;
        req0_addr  = 11'h7FF;
        step();
        req0_addr = 11'h000;
        step();
        req0_valid = 1'b0;
        repeat (6) step();
        chk("edge_rvalids", n_rv0 - base, 2);
        chk("edge_last_data", rdata, 8'd11);

        req0_valid = 1'b1;
        req0_addr  = 11'h005;
        step();
        req0_valid = 1'b0;
        w_resetn   = 1'b0;
        step();
        w_resetn = 1'b1;
        chk("post_rst_busy", busy, 0);
        base = n_rv0 + n_rv1;
        repeat (6) step();
        chk("post_rst_no_rvalid", n_rv0 + n_rv1 - base, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
